// File: rtl/hazard_stall_unit_pkg.sv
// Shared ISA decode constants and helpers for the hazard/stall control slice.
package hazard_stall_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] LU_HOLD = 1'b1;

  function automatic logic isMd(input logic [31:0] instr);
    return (instr[31:26] == OP_SPECIAL) &&
           (instr[5:0] inside {MULT, MULTU, DIV, DIVU});
  endfunction

  function automatic logic isHiLo(input logic [31:0] instr);
    return (instr[31:26] == OP_SPECIAL) &&
           (instr[5:0] inside {MFHI, MTHI, MFLO, MTLO});
  endfunction

  function automatic logic isDivOp(input logic [31:0] instr);
    return instr[5:0] inside {DIV, DIVU};
  endfunction

endpackage

// File: rtl/RegUse.sv
// Decodes which source register fields (rs/rt) an instruction actually reads.
module RegUse
  import hazard_stall_unit_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       useRs,
  output logic       useRt
);

  always_comb begin
    useRs = 1'b0;
    useRt = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          6'h00, 6'h02, 6'h03:       useRt = 1'b1;  // constant shifts read rt only
          MFHI, MFLO, 6'h0C, 6'h0D:  ;
          MTHI, MTLO, 6'h08, 6'h09:  useRs = 1'b1;
          default: begin
            useRs = 1'b1;
            useRt = 1'b1;
          end
        endcase
      end
      6'h01, 6'h06, 6'h07: useRs = 1'b1;
      6'h04, 6'h05: begin
        useRs = 1'b1;
        useRt = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: useRs = 1'b1;
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: useRs = 1'b1;
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
        useRs = 1'b1;
        useRt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_busy_counter.sv
// Multiplier/divider latency counter: busy while counting, one-cycle done pulse at expiry.
module md_busy_counter #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic isDiv,
  output logic mdBusy,
  output logic mdDone
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mdDone <= 1'b0;
    end else begin
      mdDone <= !start && (cnt == CNT_W'(1));
      if (start)
        cnt <= isDiv ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
      else if (cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  assign mdBusy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for the 5-stage pipeline: load-use hold, HI/LO
// interlock against the multiplier/divider, and flush on a taken EX branch.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] idInstruction,
  input  logic [31:0] exInstruction,
  input  logic        exMemRead,
  input  logic [4:0]  exWriteReg,
  input  logic        exBranchTaken,
  output logic        pcStall,
  output logic        ifIdStall,
  output logic        idExBubble,
  output logic        ifIdFlush,
  output logic        mdBusy,
  output logic        mdDone
);

  logic [0:0] state, stateNext;
  logic [4:0] idRs, idRt;
  logic       useRs, useRt;
  logic       luDetect, luStall, mdStall, stallAny;
  logic       exMdStart, mdBusyCnt;
  logic       unusedBits;

  assign idRs = idInstruction[25:21];
  assign idRt = idInstruction[20:16];
  assign unusedBits = ^{idInstruction[15:6], exInstruction[25:6]};

  RegUse uRegUse (
    .opcode (idInstruction[31:26]),
    .funct  (idInstruction[5:0]),
    .useRs  (useRs),
    .useRt  (useRt)
  );

  assign exMdStart = isMd(exInstruction);

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) uMdBusy (
    .clk    (clk),
    .reset  (reset),
    .start  (exMdStart),
    .isDiv  (isDivOp(exInstruction)),
    .mdBusy (mdBusyCnt),
    .mdDone (mdDone)
  );

  assign luDetect = (state == IDLE) && exMemRead && (exWriteReg != 5'd0) &&
                    ((useRs && exWriteReg == idRs) || (useRt && exWriteReg == idRt));
  assign luStall  = luDetect || (state == LU_HOLD);
  assign mdStall  = (isHiLo(idInstruction) || isMd(idInstruction)) &&
                    (exMdStart || mdBusyCnt);
  assign stallAny = luStall || mdStall;

  always_comb begin
    stateNext = IDLE;
    if (!exBranchTaken && luDetect)
      stateNext = LU_HOLD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Inputs feed these combinationally, so gate with reset to keep them quiet while it is held.
  assign pcStall    = !reset && !exBranchTaken && stallAny;
  assign ifIdStall  = !reset && !exBranchTaken && stallAny;
  assign idExBubble = !reset && (exBranchTaken || stallAny);
  assign ifIdFlush  = !reset && exBranchTaken;
  assign mdBusy     = mdBusyCnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed checks of hazard_stall_unit against a cycle-level behavioural model.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] idInstruction, exInstruction;
  logic        exMemRead, exBranchTaken;
  logic [4:0]  exWriteReg;
  logic        pcStall, ifIdStall, idExBubble, ifIdFlush, mdBusy, mdDone;

  hazard_stall_unit #(.MULT_CYCLES(5), .DIV_CYCLES(33), .CNT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .idInstruction (idInstruction),
    .exInstruction (exInstruction),
    .exMemRead     (exMemRead),
    .exWriteReg    (exWriteReg),
    .exBranchTaken (exBranchTaken),
    .pcStall       (pcStall),
    .ifIdStall     (ifIdStall),
    .idExBubble    (idExBubble),
    .ifIdFlush     (ifIdFlush),
    .mdBusy        (mdBusy),
    .mdDone        (mdDone)
  );

  always #5 clk = ~clk;

  // Instruction kinds: 0 NOP,1 ADD,2 SLL,3 LW,4 SW,5 LUI,6 BEQ,7 MFHI,8 MFLO,9 MTLO,
  // 10 MULT,11 MULTU,12 DIV,13 DIVU,14 J
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       rdRs, rdRt, md, hilo, div;
  } kind_t;

  function automatic kind_t kinfo(input int k);
    case (k)
      1:  return '{6'h00, 6'h20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      2:  return '{6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      3:  return '{6'h23, 6'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      4:  return '{6'h2B, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      5:  return '{6'h0F, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      6:  return '{6'h04, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      7:  return '{6'h00, 6'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      8:  return '{6'h00, 6'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      9:  return '{6'h00, 6'h13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      10: return '{6'h00, 6'h18, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      11: return '{6'h00, 6'h19, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      12: return '{6'h00, 6'h1A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      13: return '{6'h00, 6'h1B, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      14: return '{6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      default: return '{6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] mkInstr(input int k, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] low);
    kind_t ki;
    ki = kinfo(k);
    if (k == 0) return 32'h0;
    if (ki.op == 6'h00) return {6'h00, rs, rt, low[15:11], 5'd0, ki.fn};
    return {ki.op, rs, rt, low};
  endfunction

  int unsigned vectors = 0, miscompares = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: cycles of multiplier/divider latency still outstanding, and
  // whether the second load-use stall cycle is owed.
  int   idKind, exKind;
  logic [4:0] idRs, idRt;
  int   mdRemaining = 0;
  bit   luOwed = 0, doneNext = 0;
  logic obsPc, obsIfId, obsBub, obsFlush, obsBusy, obsDone;

  task automatic setId(input int k, input logic [4:0] rs, input logic [4:0] rt);
    idKind = k;
    idRs = (k == 0) ? 5'd0 : rs;
    idRt = (k == 0) ? 5'd0 : rt;
    idInstruction = mkInstr(k, idRs, idRt, 16'(($urandom)));
  endtask

  task automatic setEx(input int k, input bit memRd, input logic [4:0] wr);
    exKind = k;
    exInstruction = mkInstr(k, 5'($urandom), wr, 16'($urandom));
    exMemRead = memRd;
    exWriteReg = wr;
  endtask

  // Check outputs mid-cycle, then cross one rising edge and advance the model.
  task automatic step();
    kind_t idK, exK;
    bit hazard, mdStart, stall, eP, eB, eF, eBusy, eDone;
    idK = kinfo(idKind);
    exK = kinfo(exKind);
    #3;
    hazard  = !luOwed && exMemRead && exWriteReg != 0 &&
              ((idK.rdRs && exWriteReg == idRs) || (idK.rdRt && exWriteReg == idRt));
    mdStart = exK.md;
    stall   = hazard || luOwed || ((idK.hilo || idK.md) && (mdStart || mdRemaining > 0));
    eP = 0; eB = 0; eF = 0; eBusy = 0; eDone = 0;
    if (!reset) begin
      eF = exBranchTaken;
      eP = stall && !exBranchTaken;
      eB = stall || exBranchTaken;
      eBusy = mdRemaining > 0;
      eDone = doneNext;
    end
    checkVal("pcStall", pcStall, eP);
    checkVal("ifIdStall", ifIdStall, eP);
    checkVal("idExBubble", idExBubble, eB);
    checkVal("ifIdFlush", ifIdFlush, eF);
    checkVal("mdBusy", mdBusy, eBusy);
    checkVal("mdDone", mdDone, eDone);
    {obsPc, obsIfId, obsBub, obsFlush, obsBusy, obsDone} =
      {pcStall, ifIdStall, idExBubble, ifIdFlush, mdBusy, mdDone};
    @(posedge clk);
    if (reset) begin
      luOwed = 0; mdRemaining = 0; doneNext = 0;
    end else begin
      doneNext = !mdStart && mdRemaining == 1;
      luOwed = hazard && !exBranchTaken;
      if (mdStart) mdRemaining = (exK.div ? 33 : 5) - 1;
      else if (mdRemaining > 0) mdRemaining--;
    end
    #1;
  endtask

  task automatic drain();
    setEx(0, 0, 5'd0);
    setId(0, 5'd0, 5'd0);
    for (int i = 0; i < 40 && (mdRemaining > 0 || luOwed || doneNext); i++) step();
  endtask

  int cnt;

  initial begin
    reset = 1'b1;
    exBranchTaken = 1'b0;
    setId(1, 5'd8, 5'd11);
    setEx(3, 1'b1, 5'd8);
    @(posedge clk); #1;
    step();
    step();
    reset = 1'b0;
    drain();

    // Load-use: lw $8 in EX, add $10,$8,$11 in ID; two stall cycles, then the add moves on.
    setEx(3, 1'b1, 5'd8);
    setId(1, 5'd8, 5'd11);
    cnt = 0;
    step(); cnt += obsPc;
    setEx(0, 1'b0, 5'd0);
    step(); cnt += obsPc;
    step(); cnt += obsPc;
    checkVal("luStallCycles", cnt, 2);
    checkVal("luReleased", obsPc, 0);

    // Destination $0 and no-dependency cases: no stall.
    setEx(3, 1'b1, 5'd0);
    setId(1, 5'd0, 5'd11);
    step();
    checkVal("luDestZero", obsPc, 0);
    setEx(3, 1'b1, 5'd8);
    setId(1, 5'd12, 5'd13);
    step();
    checkVal("luNoDep", obsPc, 0);

    // Divide: div in EX at t, mflo from t+1 stalls 32 cycles; done at t+33.
    drain();
    setEx(12, 1'b0, 5'd0);
    setId(1, 5'd1, 5'd2);
    step();
    setEx(0, 1'b0, 5'd0);
    setId(8, 5'd0, 5'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!obsPc) break;
      cnt++;
    end
    checkVal("divStallCycles", cnt, 32);
    checkVal("divDonePulse", obsDone, 1);
    checkVal("divBusyFell", obsBusy, 0);

    // Flush while mfhi waits on a mult.
    drain();
    setEx(10, 1'b0, 5'd0);
    setId(7, 5'd0, 5'd0);
    step();
    setEx(0, 1'b0, 5'd0);
    step();
    checkVal("mdStallBeforeFlush", obsPc, 1);
    exBranchTaken = 1'b1;
    step();
    checkVal("flushIfId", obsFlush, 1);
    checkVal("flushBubble", obsBub, 1);
    checkVal("flushPcStall", obsPc, 0);
    exBranchTaken = 1'b0;
    setId(0, 5'd0, 5'd0);
    step();
    checkVal("flushBusyKeeps", obsBusy, 1);

    // Reset mid-divide at count 17.
    drain();
    setEx(12, 1'b0, 5'd0);
    setId(0, 5'd0, 5'd0);
    step();
    setEx(0, 1'b0, 5'd0);
    setId(8, 5'd0, 5'd0);
    for (int i = 0; i < 40 && mdRemaining != 17; i++) step();
    checkVal("preRstBusy", mdBusy, 1);
    checkVal("preRstStall", pcStall, 1);
    reset = 1'b1;
    #1;
    checkVal("rstMdBusy", mdBusy, 0);
    checkVal("rstPcStall", pcStall, 0);
    checkVal("rstBubble", idExBubble, 0);
    step();
    reset = 1'b0;
    setEx(10, 1'b0, 5'd0);
    setId(0, 5'd0, 5'd0);
    step();
    setEx(0, 1'b0, 5'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      cnt += obsBusy;
    end
    checkVal("multBusyCycles", cnt, 4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r, k;
      logic [4:0] wr;
      setId($urandom_range(0, 14), 5'($urandom), 5'($urandom));
      r = $urandom_range(0, 99);
      if (r < 8) k = $urandom_range(10, 13);
      else begin
        k = $urandom_range(0, 10);
        if (k == 10) k = 14;
      end
      case ($urandom_range(0, 3))
        0: wr = idRs;
        1: wr = idRt;
        2: wr = 5'd0;
        default: wr = 5'($urandom);
      endcase
      setEx(k, 1'($urandom), wr);
      exBranchTaken = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    exBranchTaken = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
